fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//   Sequences the fetch stage: drives PC-register enable and PC-mux select,
//   and decouples fetch from decode through a 2-entry {pc,instr} buffer with
//   valid/ready handshake. Handles start-up, branch redirect with flush, and
//   halt detection and drain. Sits between the fetch datapath (PC reg, +4
//   adder, branch mux, instr mem) and the decode stage.
// PARAMETERS
//   HALT_INSTR  32'hD440_0000  encoding that stops fetch (HLT)
//   BUF_DEPTH   2              decode-side buffer depth; fixed, not tunable
// PORTS
//   clk            in   1          system clock, rising edge
//   reset          in   1          asynchronous, active-low; 0 = in reset
//   start          in   1          1-cycle pulse; starts fetching from current PC
//   branch_valid   in   1          taken-branch redirect request from later stage
//   branch_target  in   `WORD      redirect address, held during branch_valid
//   imem_instr     in   `INSTR_LEN instruction at imem_pc, valid same cycle
//   imem_pc        in   `WORD      current PC register value (cur_pc)
//   pc_en          out  1          PC register load enable
//   pc_src         out  1          mux select: 1 = branch_target, 0 = PC+4
//   dec_valid      out  1          buffer head valid toward decode
//   dec_ready      in   1          decode accepts head this cycle
//   dec_instr      out  `INSTR_LEN buffer head instruction
//   dec_pc         out  `WORD      buffer head PC
//   halted         out  1          sticky; fetch halted and buffer drained
//   state          out  3          FSM state, debug only
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, buffer empty, pc_en=0, pc_src=0,
//     dec_valid=0, dec_instr=0, dec_pc=0, halted=0. Mid-operation reset kills
//     all buffered entries immediately; no handshake completes in that cycle.
//   States: IDLE=0, FETCH=1, DRAIN=2, HALT=3.
//   IDLE: pc_en=0, no push. start=1 -> FETCH next cycle.
//   FETCH, no branch: push {imem_pc,imem_instr} and pc_en=1, pc_src=0 when
//     push_ok = (count<2) | dec_ready. Else stall: pc_en=0, nothing pushed, PC
//     held. If pushed instr==HALT_INSTR: pc_en=0 that cycle, -> DRAIN.
//   DRAIN: pc_en=0, no push; buffer empties via decode; count==0 -> HALT.
//   HALT: halted=1, pc_en=0; start and branch_valid ignored; exit only by reset.
//   branch_valid in FETCH or DRAIN (priority over everything else):
//     pc_src=1, pc_en=1, current imem_instr NOT pushed, buffer flushed,
//     dec_valid forced 0 that cycle (no pop), state -> FETCH. Target instr is
//     presented next cycle and pushed normally. branch_valid in IDLE ignored.
//   Buffer: 2-entry FIFO, 1-bit wrapping rd/wr pointers, 2-bit count (0..2).
//     Push+pop same cycle: count unchanged, legal when full. Pop only when
//     dec_valid&dec_ready. dec_* driven from registered head entry (no
//     combinational imem->dec path); dec_instr/dec_pc hold value when empty.
//   Throughput: 1 instr/cycle with dec_ready=1; latency imem -> dec_valid 1 cycle.
//   Simultaneous start+branch_valid in IDLE: start wins, branch ignored.
//   pc_src=0 whenever branch_valid=0; pc_en never 1 in IDLE or HALT.
// STRUCTURE
//   Shared defines header: `WORD (64), `INSTR_LEN (32), FS_IDLE/FS_FETCH/
//     FS_DRAIN/FS_HALT encodings, HALT_INSTR default.
//   Sub-module fetch_buf: 2-entry FIFO (push, pop, flush, data, count, full,
//     empty); fetch_ctrl holds FSM + pc_en/pc_src logic and instantiates it.
// TESTING
//   1. reset=0 then 1, start pulse, imem_pc 0,4,8..; dec_ready=1 -> pc_en=1
//      every cycle, dec_pc = 0,4,8 in consecutive cycles one cycle later.
//   2. dec_ready=0 for 5 cycles in FETCH -> exactly 2 entries pushed, pc_en=0
//      from 3rd cycle, PC held; dec_ready=1 -> entries drain in order, no loss.
//   3. branch_valid=1, target 0x100, buffer full -> pc_src=1, pc_en=1,
//      dec_valid=0 next cycle; following dec_pc = 0x100, none of old entries.
//   4. imem_instr=32'hD440_0000 at pc 0x20 -> pc_en=0, DRAIN; after 0x20
//      popped, state=HALT, halted=1; later start/branch_valid have no effect.
//   5. branch_valid in DRAIN (target 0x40) -> back to FETCH, halted stays 0,
//      next dec_pc = 0x40.
//   6. reset asserted with 2 entries buffered -> dec_valid=0, state=IDLE
//      immediately (before next clk edge); no pc_en until new start.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM encoding and the halt opcode for the fetch control block.
package fetch_ctrl_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int BUF_DEPTH = 2;

  localparam logic [INSTR_LEN-1:0] HALT_INSTR_DEFAULT = 32'hD440_0000;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_DRAIN = 3'd2,
    FS_HALT  = 3'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc,instr} FIFO between fetch and decode with a registered head
// so decode never sees a combinational path from instruction memory.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WORD-1:0]      push_pc,
  input  logic [INSTR_LEN-1:0] push_instr,
  output logic [WORD-1:0]      head_pc,
  output logic [INSTR_LEN-1:0] head_instr,
  output logic [1:0]           count,
  output logic                 full,
  output logic                 empty
);

  logic [WORD-1:0]      pc_mem    [BUF_DEPTH];
  logic [INSTR_LEN-1:0] instr_mem [BUF_DEPTH];
  logic                 wr_ptr, rd_ptr, wr_next, rd_next;
  logic                 do_push, do_pop;
  logic [1:0]           count_next;
  logic [WORD-1:0]      head_pc_next;
  logic [INSTR_LEN-1:0] head_instr_next;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // The head register is loaded with whatever entry will sit at rd_ptr after
  // this edge, bypassing the memory when that entry is being written now.
  always_comb begin
    rd_next         = rd_ptr ^ do_pop;
    wr_next         = wr_ptr ^ do_push;
    count_next      = count + 2'(do_push) - 2'(do_pop);
    head_pc_next    = head_pc;
    head_instr_next = head_instr;
    if (flush) begin
      rd_next    = 1'b0;
      wr_next    = 1'b0;
      count_next = 2'd0;
    end else if (count_next != 2'd0) begin
      if (do_push && (wr_ptr == rd_next)) begin
        head_pc_next    = push_pc;
        head_instr_next = push_instr;
      end else begin
        head_pc_next    = pc_mem[rd_next];
        head_instr_next = instr_mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_pc    <= head_pc_next;
      head_instr <= head_instr_next;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable / mux select, start-up, branch redirect
// with buffer flush, and halt detection followed by a decode-side drain.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [INSTR_LEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 branch_valid,
  input  logic [WORD-1:0]      branch_target,
  input  logic [INSTR_LEN-1:0] imem_instr,
  input  logic [WORD-1:0]      imem_pc,
  output logic                 pc_en,
  output logic                 pc_src,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [INSTR_LEN-1:0] dec_instr,
  output logic [WORD-1:0]      dec_pc,
  output logic                 halted,
  output logic [2:0]           state
);

  fetch_state_t cur_state, next_state;
  logic         redirect, push, pop, push_ok;
  logic [1:0]   count;
  logic         full, empty;
  logic         unused_target;

  // The target itself steers the datapath mux; control only needs the request.
  assign unused_target = ^branch_target;

  assign redirect  = branch_valid & ((cur_state == FS_FETCH) | (cur_state == FS_DRAIN));
  assign push_ok   = ~full | dec_ready;
  assign dec_valid = ~empty & ~redirect;
  assign pop       = dec_valid & dec_ready;
  assign halted    = (cur_state == FS_HALT);
  assign state     = cur_state;

  always_comb begin
    next_state = cur_state;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    push       = 1'b0;
    unique case (cur_state)
      FS_IDLE: begin
        if (start) next_state = FS_FETCH;
      end
      FS_FETCH: begin
        if (redirect) begin
          pc_en  = 1'b1;
          pc_src = 1'b1;
        end else if (push_ok) begin
          push = 1'b1;
          if (imem_instr == HALT_INSTR) next_state = FS_DRAIN;
          else                          pc_en      = 1'b1;
        end
      end
      FS_DRAIN: begin
        if (redirect) begin
          pc_en      = 1'b1;
          pc_src     = 1'b1;
          next_state = FS_FETCH;
        end else if (empty) begin
          next_state = FS_HALT;
        end
      end
      FS_HALT: begin
        next_state = FS_HALT;
      end
      default: next_state = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= FS_IDLE;
    else        cur_state <= next_state;
  end

  fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_pc    (imem_pc),
    .push_instr (imem_instr),
    .head_pc    (dec_pc),
    .head_instr (dec_instr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule
